// File: rtl/obi_instr_mem_if.sv
// OBI instruction-fetch channel between the core's fetch port and the instruction memory.
interface obi_instr_mem_if;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;

  logic             instr_req_i;
  logic [AddrW-1:0] instr_addr_i;
  logic             instr_gnt_o;
  logic             instr_rvalid_o;
  logic [DataW-1:0] instr_rdata_o;

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o
  );

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o
  );
endinterface

// File: rtl/obi_instr_mem.sv
// OBI instruction-memory responder: word RAM with preload port, fixed response latency
// and a bounded number of outstanding in-order fetches.
module obi_instr_mem #(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 rst_ni,
  obi_instr_mem_if.slave       bus,
  input  logic                 stall_i,
  input  logic                 load_we_i,
  input  logic [31:0]          load_addr_i,
  input  logic [31:0]          load_data_i,
  output logic                 oob_o,
  output logic [3:0]           outstanding_o
);

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned WordW = AddrW - 2;
  localparam int unsigned IdxW  = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW  = 4;

  typedef struct packed {
    logic             valid;
    logic             oob;
    logic [DataW-1:0] data;
  } resp_t;

  logic [DataW-1:0] mem [DEPTH_WORDS];
  resp_t            pipe_q [LATENCY];
  resp_t            fetch_resp;
  logic [CntW-1:0]  cnt_q;
  logic [AddrW-1:0] fetch_off;
  logic [AddrW-1:0] load_off;
  logic             fetch_in_range;
  logic             load_in_range;
  logic [IdxW-1:0]  fetch_idx;
  logic [IdxW-1:0]  load_idx;
  logic             accept;
  logic             resp_valid;
  logic             unused_addr_lsb;

  // Unsigned offset: addresses below BASE_ADDR wrap to a huge index and fall out of range.
  assign fetch_off      = bus.instr_addr_i - BASE_ADDR;
  assign load_off       = load_addr_i - BASE_ADDR;
  assign fetch_in_range = fetch_off[AddrW-1:2] < WordW'(DEPTH_WORDS);
  assign load_in_range  = load_off[AddrW-1:2] < WordW'(DEPTH_WORDS);
  assign fetch_idx      = fetch_off[IdxW+1:2];
  assign load_idx       = load_off[IdxW+1:2];
  assign unused_addr_lsb = ^{fetch_off[1:0], load_off[1:0]};

  assign bus.instr_gnt_o = rst_ni & bus.instr_req_i & ~stall_i & (cnt_q < CntW'(MAX_OUTSTANDING));
  assign accept          = bus.instr_req_i & bus.instr_gnt_o;

  always_comb begin
    fetch_resp       = '0;
    fetch_resp.valid = accept;
    fetch_resp.oob   = accept & ~fetch_in_range;
    fetch_resp.data  = fetch_in_range ? mem[fetch_idx] : '0;
  end

  // Preload port; RAM keeps its contents across reset, read-first against a same-edge fetch.
  always_ff @(posedge clk) begin
    if (load_we_i && load_in_range) begin
      mem[load_idx] <= load_data_i;
    end
  end

  // Response shift register; data only advances with a valid entry so rdata holds between pulses.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0].valid <= fetch_resp.valid;
      pipe_q[0].oob   <= fetch_resp.oob;
      if (fetch_resp.valid) begin
        pipe_q[0].data <= fetch_resp.data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_q[i].valid <= pipe_q[i-1].valid;
        pipe_q[i].oob   <= pipe_q[i-1].oob;
        if (pipe_q[i-1].valid) begin
          pipe_q[i].data <= pipe_q[i-1].data;
        end
      end
    end
  end

  assign resp_valid         = pipe_q[LATENCY-1].valid;
  assign bus.instr_rvalid_o = resp_valid;
  assign bus.instr_rdata_o  = pipe_q[LATENCY-1].data;
  assign oob_o              = pipe_q[LATENCY-1].oob;

  // Outstanding count: accepted but not yet presented.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (accept && !resp_valid) begin
      cnt_q <= cnt_q + CntW'(1);
    end else if (!accept && resp_valid) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_obi_instr_mem.sv
// Bench for obi_instr_mem: three configurations share one stimulus stream and are each
// checked every cycle against a due-time queue model, plus table and directed sequences.
module tb_obi_instr_mem;

  localparam int unsigned NDUT = 3;

  logic        clk;
  logic        rst_ni;
  logic        req;
  logic [31:0] addr;
  logic        stall;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic        gnt_w    [NDUT];
  logic        rv_w     [NDUT];
  logic [31:0] rdata_w  [NDUT];
  logic        oob_w    [NDUT];
  logic [3:0]  outst_w  [NDUT];

  obi_instr_mem_if bus0 ();
  obi_instr_mem_if bus1 ();
  obi_instr_mem_if bus2 ();

  assign bus0.instr_req_i = req;  assign bus0.instr_addr_i = addr;
  assign bus1.instr_req_i = req;  assign bus1.instr_addr_i = addr;
  assign bus2.instr_req_i = req;  assign bus2.instr_addr_i = addr;
  assign gnt_w[0] = bus0.instr_gnt_o; assign rv_w[0] = bus0.instr_rvalid_o; assign rdata_w[0] = bus0.instr_rdata_o;
  assign gnt_w[1] = bus1.instr_gnt_o; assign rv_w[1] = bus1.instr_rvalid_o; assign rdata_w[1] = bus1.instr_rdata_o;
  assign gnt_w[2] = bus2.instr_gnt_o; assign rv_w[2] = bus2.instr_rvalid_o; assign rdata_w[2] = bus2.instr_rdata_o;

  obi_instr_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(2)) u_dut0 (
    .clk(clk), .rst_ni(rst_ni), .bus(bus0), .stall_i(stall), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_data_i(load_data), .oob_o(oob_w[0]), .outstanding_o(outst_w[0]));

  obi_instr_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3), .MAX_OUTSTANDING(4)) u_dut1 (
    .clk(clk), .rst_ni(rst_ni), .bus(bus1), .stall_i(stall), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_data_i(load_data), .oob_o(oob_w[1]), .outstanding_o(outst_w[1]));

  obi_instr_mem #(.DEPTH_WORDS(16), .BASE_ADDR(32'h100), .LATENCY(3), .MAX_OUTSTANDING(1)) u_dut2 (
    .clk(clk), .rst_ni(rst_ni), .bus(bus2), .stall_i(stall), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_data_i(load_data), .oob_o(oob_w[2]), .outstanding_o(outst_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned cfg_lat(int d);
    return (d == 0) ? 1 : 3;
  endfunction
  function automatic int unsigned cfg_max(int d);
    return (d == 0) ? 2 : (d == 1) ? 4 : 1;
  endfunction
  function automatic logic [31:0] cfg_base(int d);
    return (d == 2) ? 32'h100 : 32'h0;
  endfunction
  function automatic int unsigned cfg_depth(int d);
    return (d == 2) ? 16 : 1024;
  endfunction

  int total;
  int bad;

  // Reference model: RAM image plus a queue of responses stamped with the edge they appear after.
  logic [31:0] m_mem  [NDUT][1024];
  int          m_cnt  [NDUT];
  bit          m_rv   [NDUT];
  logic [31:0] m_rdata[NDUT];
  bit          m_oob  [NDUT];
  bit          m_acc  [NDUT];
  int unsigned f_due  [NDUT][16];
  logic [31:0] f_data [NDUT][16];
  bit          f_oob  [NDUT][16];
  int          m_head [NDUT];
  int          m_n    [NDUT];
  int unsigned ecnt;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s u%0d act=%h exp=%h t=%0t", name, d, act, exp, $time);
    end
  endtask

  function automatic bit model_gnt(int d);
    return rst_ni && req && !stall && (m_cnt[d] < int'(cfg_max(d)));
  endfunction

  task automatic model_edge();
    logic [31:0] off, loff, rd;
    bit inr, acc;
    int slot;
    ecnt++;
    for (int d = 0; d < int'(NDUT); d++) begin
      off = addr - cfg_base(d);
      inr = (off >> 2) < cfg_depth(d);
      acc = model_gnt(d);
      m_acc[d] = acc;
      rd = inr ? m_mem[d][int'(off >> 2)] : 32'h0;
      if (!rst_ni) begin
        m_n[d] = 0; m_cnt[d] = 0; m_rv[d] = 0; m_rdata[d] = 0; m_oob[d] = 0;
      end else begin
        m_cnt[d] = m_cnt[d] + (acc ? 1 : 0) - (m_rv[d] ? 1 : 0);
        if (acc) begin
          slot = (m_head[d] + m_n[d]) % 16;
          f_due[d][slot]  = ecnt + cfg_lat(d) - 1;
          f_data[d][slot] = rd;
          f_oob[d][slot]  = !inr;
          m_n[d]++;
        end
        if (m_n[d] > 0 && f_due[d][m_head[d]] == ecnt) begin
          m_rv[d]    = 1;
          m_rdata[d] = f_data[d][m_head[d]];
          m_oob[d]   = f_oob[d][m_head[d]];
          m_head[d]  = (m_head[d] + 1) % 16;
          m_n[d]--;
        end else begin
          m_rv[d]  = 0;
          m_oob[d] = 0;
        end
      end
      loff = load_addr - cfg_base(d);
      if (load_we && ((loff >> 2) < cfg_depth(d))) m_mem[d][int'(loff >> 2)] = load_data;
    end
  endtask

  task automatic monitor();
    for (int d = 0; d < int'(NDUT); d++) begin
      chk("gnt",    d, 32'(gnt_w[d]),   32'(model_gnt(d)));
      chk("rvalid", d, 32'(rv_w[d]),    32'(m_rv[d]));
      chk("rdata",  d, rdata_w[d],      m_rdata[d]);
      chk("oob",    d, 32'(oob_w[d]),   32'(m_oob[d]));
      chk("outst",  d, 32'(outst_w[d]), 32'(m_cnt[d]));
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model on the edge, return just after it.
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    req = 0; stall = 0; load_we = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        oob;
  } vec_t;

  vec_t tbl [8];
  logic [31:0] pre_addr [6];
  logic [31:0] pre_data [6];

  initial begin
    int n, k, peak, nrv, grants;
    int first_acc, first_rv, last_rv;
    bit got;
    logic [31:0] exp_burst [4];

    total = 0; bad = 0; ecnt = 0;
    for (int d = 0; d < int'(NDUT); d++) begin
      m_cnt[d] = 0; m_rv[d] = 0; m_rdata[d] = 0; m_oob[d] = 0; m_head[d] = 0; m_n[d] = 0;
      for (int i = 0; i < 1024; i++) m_mem[d][i] = 32'h0;
    end
    rst_ni = 0; req = 0; addr = 0; stall = 0; load_we = 0; load_addr = 0; load_data = 0;
    @(posedge clk); #1;

    // Fill every word, with the first few writes landing while reset is held.
    for (int a = 0; a < 1088; a++) begin
      rst_ni    = (a >= 8);
      load_we   = 1;
      load_addr = 32'(a * 4) | 32'($urandom_range(0, 3));
      load_data = $urandom;
      cycle();
    end
    idle(2);
    chk("reset_outst", 0, 32'(outst_w[0]), 32'h0);

    pre_addr = '{32'h0, 32'h4, 32'h8, 32'h10, 32'hFFC, 32'h1000};
    pre_data = '{32'h0000_0093, 32'h0010_0113, 32'hDEAD_BEEF, 32'hCAFE_0010, 32'h1234_5678, 32'hBAD0_BAD0};
    for (int i = 0; i < 6; i++) begin
      load_we = 1; load_addr = pre_addr[i]; load_data = pre_data[i];
      cycle();
    end
    load_we = 0;

    tbl[0] = '{32'h0000_0004, 32'h0010_0113, 1'b0};
    tbl[1] = '{32'h0000_0000, 32'h0000_0093, 1'b0};
    tbl[2] = '{32'h0000_0007, 32'h0010_0113, 1'b0};
    tbl[3] = '{32'h0000_0008, 32'hDEAD_BEEF, 1'b0};
    tbl[4] = '{32'h0000_0FFC, 32'h1234_5678, 1'b0};
    tbl[5] = '{32'h0000_1000, 32'h0000_0000, 1'b1};
    tbl[6] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    tbl[7] = '{32'h0000_0012, 32'hCAFE_0010, 1'b0};

    // Single fetches on the latency-1 instance against constant expectations.
    for (int i = 0; i < 8; i++) begin
      idle(4);
      req = 1; addr = tbl[i].addr; got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        cycle();
        got = m_acc[0];
      end
      req = 0;
      chk("tbl_accept", i, 32'(got), 32'h1);
      chk("tbl_rvalid", i, 32'(rv_w[0]), 32'h1);
      chk("tbl_rdata",  i, rdata_w[0], tbl[i].data);
      chk("tbl_oob",    i, 32'(oob_w[0]), 32'(tbl[i].oob));
    end

    // Stall holds off grant; grant appears as soon as stall drops.
    idle(6);
    req = 1; addr = 32'h4; stall = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_gnt", i, 32'(gnt_w[0]), 32'h0);
      chk("stall_rv",  i, 32'(rv_w[0]),  32'h0);
      cycle();
    end
    stall = 0;
    #1;
    chk("stall_release_gnt", 0, 32'(gnt_w[0]), 32'h1);
    cycle();
    req = 0;

    // Back-to-back burst on the latency-3 / 4-outstanding instance.
    idle(8);
    exp_burst = '{32'h0000_0093, 32'h0010_0113, 32'hDEAD_BEEF, m_mem[1][3]};
    req = 1; addr = 32'h0; k = 0; n = 0; peak = 0; nrv = 0;
    first_acc = -1; first_rv = -1; last_rv = -1;
    while (k < 4 && n < 30) begin
      cycle(); n++;
      if (m_acc[1]) begin
        if (k == 0) first_acc = int'(ecnt);
        k++; addr = 32'(k * 4);
      end
      if (int'(outst_w[1]) > peak) peak = int'(outst_w[1]);
      if (rv_w[1]) begin
        if (first_rv < 0) first_rv = int'(ecnt);
        last_rv = int'(ecnt);
        if (nrv < 4) chk("burst_data", nrv, rdata_w[1], exp_burst[nrv]);
        nrv++;
      end
    end
    req = 0;
    chk("burst_accept_cycles", 1, 32'(n), 32'd4);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (int'(outst_w[1]) > peak) peak = int'(outst_w[1]);
      if (rv_w[1]) begin
        if (first_rv < 0) first_rv = int'(ecnt);
        last_rv = int'(ecnt);
        if (nrv < 4) chk("burst_data", nrv, rdata_w[1], exp_burst[nrv]);
        nrv++;
      end
    end
    chk("burst_rv_count", 1, 32'(nrv), 32'd4);
    chk("burst_first_rv", 1, 32'(first_rv - first_acc), 32'd2);
    chk("burst_rv_span",  1, 32'(last_rv - first_rv), 32'd3);
    chk("burst_peak",     1, 32'(peak), 32'd3);

    // Single-outstanding instance under continuous request: one grant every fourth cycle.
    idle(8);
    req = 1; addr = 32'h104; grants = 0; peak = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (gnt_w[2]) grants++;
      if (int'(outst_w[2]) > peak) peak = int'(outst_w[2]);
      cycle();
    end
    req = 0;
    chk("max1_grants", 2, 32'(grants), 32'd4);
    chk("max1_peak",   2, 32'(peak), 32'd1);

    // Reset with two fetches in flight drops them; RAM survives.
    idle(8);
    req = 1; addr = 32'h10;
    cycle(); cycle();
    chk("rst_inflight", 1, 32'(outst_w[1]), 32'd2);
    rst_ni = 0;
    #1;
    chk("rst_gnt", 0, 32'(gnt_w[0]), 32'h0);
    chk("rst_gnt", 1, 32'(gnt_w[1]), 32'h0);
    cycle();
    rst_ni = 1; req = 0;
    chk("rst_outst", 1, 32'(outst_w[1]), 32'h0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rst_no_rv", 1, 32'(rv_w[1]), 32'h0);
    end
    req = 1; addr = 32'h10; got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      cycle();
      got = m_acc[1];
    end
    req = 0;
    chk("rst_refetch_accept", 1, 32'(got), 32'h1);
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      if (rv_w[1]) got = 1;
      else cycle();
    end
    chk("rst_refetch_rv",    1, 32'(got), 32'h1);
    chk("rst_refetch_rdata", 1, rdata_w[1], 32'hCAFE_0010);

    // Random traffic, preloads and occasional resets, all judged by the model.
    for (int i = 0; i < 1500; i++) begin
      int sel;
      rst_ni  = ($urandom_range(0, 199) != 0);
      req     = ($urandom_range(0, 3) != 0);
      stall   = ($urandom_range(0, 4) == 0);
      sel     = int'($urandom_range(0, 7));
      addr    = (sel < 6) ? 32'($urandom_range(0, 32'h10FF)) : (sel == 6) ? $urandom : 32'hFFFF_FFFC;
      load_we = ($urandom_range(0, 7) == 0);
      load_addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h10FF));
      load_data = $urandom;
      cycle();
    end
    rst_ni = 1;
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obi_instr_mem.md
Name: obi_instr_mem

Overview:
- OBI instruction-memory responder that sits directly upstream of the core's instruction fetch port.
- Drives the core's instr_gnt_i, instr_rvalid_i and instr_rdata_i in response to instr_req_o and instr_addr_o.
- Word-addressed RAM with a bench-side preload port, a configurable fixed response latency and a bounded number of outstanding transactions.
- In-order responses only; a stall input lets the bench throttle grants.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, >= 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; word-aligned.
- LATENCY, 1: cycles from accepted request to rvalid; range 1..8.
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered requests; range 1..LATENCY+1.

Ports:
- clk  input  1  clock
- rst_ni  input  1  synchronous active-low reset
- instr_req_i  input  1  fetch request from core
- instr_addr_i  input  32  fetch byte address from core
- instr_gnt_o  output  1  grant to core
- instr_rvalid_o  output  1  response valid, one-cycle pulse per response
- instr_rdata_o  output  32  response data
- stall_i  input  1  bench backpressure; suppresses grant
- load_we_i  input  1  preload write enable
- load_addr_i  input  32  preload byte address
- load_data_i  input  32  preload word
- oob_o  output  1  pulses with rvalid when the response address was out of range
- outstanding_o  output  4  current outstanding count

Behaviour:
- Clocking and reset:
  - One clock, clk; reset is synchronous and active-low on rst_ni.
  - Reset clears the response pipeline and the outstanding counter; RAM contents are kept.
  - Reset values: instr_rvalid_o=0, instr_rdata_o=0, oob_o=0, outstanding_o=0.
  - Asserting rst_ni mid-operation drops all in-flight responses; no rvalid follows for them.
- Grant:
  - Combinational: instr_gnt_o = instr_req_i & ~stall_i & (count < MAX_OUTSTANDING).
  - Grant is never asserted while rst_ni=0.
- Accept:
  - A request is accepted in any cycle with instr_req_i & instr_gnt_o.
  - Word index = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored.
  - In range means index < DEPTH_WORDS, evaluated with unsigned subtraction. An addr below BASE_ADDR wraps to a large index and is out of range.
  - Data is read at accept time, read-first: a same-cycle preload to the same word does not affect that read.
- Response:
  - A request accepted in cycle N gives instr_rvalid_o=1 in cycle N+LATENCY, with instr_rdata_o = the word, or 0 when out of range; oob_o=1 in that case.
  - Responses come in acceptance order. Back-to-back accepts give back-to-back rvalids.
  - There is no ready from the core; a response is consumed when rvalid is presented.
  - instr_rdata_o holds its last value while rvalid=0.
- Outstanding counter:
  - +1 on accept, -1 on rvalid; unchanged when both happen in the same cycle.
  - Never exceeds MAX_OUTSTANDING and never underflows.
  - With MAX_OUTSTANDING < LATENCY+1, grant drops when count reaches the limit. It reasserts in the cycle after the rvalid that brings count below the limit, since count is registered.
- Pipeline:
  - LATENCY-stage shift register of {valid, data, oob}.
- Preload:
  - load_we_i writes load_data_i at word (load_addr_i - BASE_ADDR) >> 2 on the clock edge.
  - Out-of-range preloads are ignored. Preload is allowed at any time, including during reset.
- Core request changes:
  - instr_addr_i changing while req=1 and gnt=0 is tolerated; only the address present at accept is used.

Test Plan:
- Preload 0x0000_0093 at 0x0 and 0x0010_0113 at 0x4; LATENCY=1; single req to 0x4 accepted at cycle 10 -> rvalid=1 at cycle 11 with rdata=0x0010_0113, oob=0.
- LATENCY=3, MAX_OUTSTANDING=4; req held high on addresses 0x0,0x4,0x8,0xC -> gnt on 4 consecutive cycles, then 4 consecutive rvalids starting 3 cycles after the first accept, data in order, outstanding peaks at 3.
- LATENCY=3, MAX_OUTSTANDING=1; continuous req -> gnt every 4th cycle, outstanding_o never exceeds 1.
- stall_i=1 for 5 cycles with req=1 -> gnt=0 for those cycles, no rvalid; the first gnt comes the cycle stall_i drops.
- req to BASE_ADDR+4*DEPTH_WORDS -> rvalid with rdata=0, oob=1. Also a preload to that address -> no RAM word changes.
- Accept 2 requests at LATENCY=3, assert rst_ni=0 one cycle later for 1 cycle -> no rvalid afterwards, outstanding_o=0, and RAM still returns the preloaded words on the next fetch.
